axi_mem_responder: RTL
======================

Name: axi_mem_responder

Overview:
- AXI4 slave (responder) terminating the core-side AXI master port; on-chip SRAM backing store for FPGA bring-up and Verilator runs.
- Sits downstream of the RISC-V atomics adapter; sees only plain AXI4 reads and writes.
- One read and one write burst in flight at a time, each independent; separate SRAM read and write ports.

Parameters:
- BASE_ADDR, 64'h0000_0000, byte address of word 0.
- DEPTH, 16384, SRAM words (power of two).
- DATA_WIDTH, drac_pkg::HPDCACHE_MEM_DATA_WIDTH (512), AXI data width.
- ID_WIDTH, drac_pkg::HPDCACHE_MEM_TID_WIDTH, AXI ID width.
- RESP_LATENCY, 4, extra cycles inserted before the first R beat and before B (only with the macro).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; synchronous and active-low
- axi_req_i  in  fpga_pkg::core_axi_req_t  AW/W/AR channels plus b_ready/r_ready from the master
- axi_resp_o  out  fpga_pkg::core_axi_resp_t  aw/w/ar_ready, B and R channels

Behaviour:
- Reset: while rstn_i=0 all readies, b_valid and r_valid are 0; both FSMs go to IDLE; counters and registers are cleared. Reset mid-burst abandons the burst; no response is issued.
- Address math:
  - LSB = log2(DATA_WIDTH/8) = 6.
  - word index = (addr - BASE_ADDR)[LSB +: log2(DEPTH)].
  - In range: BASE_ADDR <= addr < BASE_ADDR + DEPTH*64, checked per beat.
  - INCR: beat address += 2^size, aligned down to size. FIXED: same address every beat. WRAP: error.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: aw_ready=1. AW handshake latches id, addr, len, size, burst; goes to W_DATA.
  - W_DATA: w_ready=1. Each W handshake writes SRAM bytes per wstrb on that edge, only if the beat is in range, burst!=WRAP and beat count <= len. Beats beyond len+1 are discarded.
  - The w_last handshake moves to W_RESP.
  - W_RESP: b_valid=1 with b_id=latched id. Held stable until b_ready, then W_IDLE.
  - b_resp=SLVERR if any beat was out of range, burst was WRAP, or w_last arrived at a beat count != len+1; otherwise OKAY.
- Read FSM (R_IDLE, R_FETCH, R_SEND):
  - R_IDLE: ar_ready=1. AR handshake latches id, addr, len, size, burst.
  - R_FETCH: drives the SRAM read address; data is registered at the edge.
  - R_SEND: r_valid=1, r_data=SRAM word (0 if error), r_resp=OKAY or SLVERR per beat, r_last=(beat==len), r_id=latched id. All fields are held until r_ready.
  - After the handshake: go to R_FETCH if beats remain, else R_IDLE.
  - Latency: AR accepted in cycle N gives first r_valid in cycle N+2. With r_ready held high, one beat every 2 cycles.
- Same-cycle read and write to one word: the read returns pre-write data (SRAM write-first is not allowed).
- aw_ready and ar_ready are independent: both may handshake in the same cycle.
- User fields are driven 0. aw.atop != 0 is treated as a plain write.

Optional Feature:
- Macro: AXI_MEM_RESP_LAT_EN.
- Defined: adds R_WAIT before the first R_FETCH and W_WAIT before W_RESP. Each counts RESP_LATENCY cycles, so first r_valid = N+2+RESP_LATENCY and b_valid arrives RESP_LATENCY cycles later. A RESP_LATENCY=0 build matches the undefined build.
- Undefined: no wait states and no counter logic.

Decomposition:
- fpga_pkg holds: the resp enum (OKAY=2'b00, SLVERR=2'b10); burst encodings; the addr_ctx_t struct {id, addr, len, size, burst}; and the next_beat_addr() function shared by both FSMs.
- One sub-module, axi_mem_sram: DEPTH x DATA_WIDTH, one registered read port and one byte-enabled write port, for BRAM inference.

Test Plan:
- Single write then read: AW addr BASE+0x40, len 0, wstrb all-1, data 0xA5..A5. Expect B OKAY with same id, then R data 0xA5..A5, r_last=1, first r_valid at AR+2.
- INCR burst: len 3 write of 4 distinct words at BASE+0x100, then len 3 read with r_ready toggling every cycle. Expect 4 beats in order, r_last on beat 3 only, data stable while stalled.
- Partial strobe: write wstrb=64'h0F then read. Expect only bytes 0-3 updated, remaining bytes unchanged.
- Out of range: read at BASE + DEPTH*64, len 1. Expect 2 beats with SLVERR, data 0. Write there: expect B SLVERR and SRAM untouched.
- Protocol errors: w_last asserted on beat 1 with len 3, expect B SLVERR; WRAP burst, expect SLVERR.
- Reset mid-read: rstn_i=0 during R_SEND. Expect r_valid=0 next cycle and a clean new AR after release. With AXI_MEM_RESP_LAT_EN and RESP_LATENCY=4, first r_valid at AR+6.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared AXI4 types, encodings and beat-address helper for the on-chip memory responder.
// The AXI_MEM_RESP_LAT_EN macro adds the wait states to the FSM state enums.
package fpga_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 512;
    localparam int AXI_ID_W   = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } addr_ctx_t;

    typedef struct packed {
        addr_ctx_t  ctx;
        logic [5:0] atop;
        logic       user;
    } aw_chan_t;

    typedef struct packed {
        addr_ctx_t ctx;
        logic      user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic                    user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        axi_resp_e           resp;
        logic                user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        axi_resp_e             resp;
        logic                  last;
        logic                  user;
    } r_chan_t;

    typedef struct packed {
        logic     aw_valid;
        aw_chan_t aw;
        logic     w_valid;
        w_chan_t  w;
        logic     b_ready;
        logic     ar_valid;
        ar_chan_t ar;
        logic     r_ready;
    } core_axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } core_axi_resp_t;

`ifdef AXI_MEM_RESP_LAT_EN
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FETCH, R_SEND} rstate_e;
`else
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_e;
`endif

    // INCR aligns down to the beat size before stepping; FIXED and WRAP hold the address.
    function automatic logic [AXI_ADDR_W-1:0] next_beat_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                             input logic [2:0] size,
                                                             input logic [1:0] burst);
        logic [AXI_ADDR_W-1:0] step;
        step = AXI_ADDR_W'(1) << size;
        if (burst == BURST_INCR) return (addr & ~(step - AXI_ADDR_W'(1))) + step;
        return addr;
    endfunction

endpackage

// File: rtl/axi_mem_responder_sram.sv
// DEPTH x DATA_WIDTH memory: registered read port and byte-enabled write port.
// A same-cycle read of the word being written returns the old contents.
module axi_mem_sram #(
    parameter int DEPTH      = 16384,
    parameter int DATA_WIDTH = 512,
    localparam int AW        = $clog2(DEPTH),
    localparam int BE        = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [BE-1:0]         wbe_i,
    input  logic [DATA_WIDTH-1:0] wdata_i
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
        if (we_i) begin
            for (int b = 0; b < BE; b++) begin
                if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip SRAM; one read and one write burst in flight independently.
// Define AXI_MEM_RESP_LAT_EN to insert RESP_LATENCY wait cycles before the first R beat and before B.
module axi_mem_responder import fpga_pkg::*; #(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000,
    parameter int          DEPTH        = 16384,
    parameter int          DATA_WIDTH   = AXI_DATA_W,
    parameter int          ID_WIDTH     = AXI_ID_W,
    parameter int          RESP_LATENCY = 4
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  core_axi_req_t  axi_req_i,
    output core_axi_resp_t axi_resp_o
);
    localparam int          LSB       = $clog2(DATA_WIDTH / 8);
    localparam int          IDXW      = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << LSB;

    wstate_e    w_state_q;
    addr_ctx_t  wctx_q;
    logic [8:0] wcnt_q;
    logic       werr_q, aw_ready_q, w_ready_q, b_valid_q;
    axi_resp_e  b_resp_q;

    rstate_e    r_state_q;
    addr_ctx_t  rctx_q;
    logic [7:0] rbeat_q;
    logic       rerr_q, r_last_q, ar_ready_q, r_valid_q;
    axi_resp_e  r_resp_q;

`ifdef AXI_MEM_RESP_LAT_EN
    logic [15:0] lat_w_q, lat_r_q;
`endif

    // 65-bit difference: bit 64 is the borrow, i.e. the address lies below BASE_ADDR.
    logic [64:0]           w_diff, r_diff;
    logic                  w_bad, r_bad, w_hs, sram_we, sram_re;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  unused_bits;

    assign w_diff  = {1'b0, wctx_q.addr} - {1'b0, BASE_ADDR};
    assign r_diff  = {1'b0, rctx_q.addr} - {1'b0, BASE_ADDR};
    assign w_bad   = w_diff[64] || (w_diff[63:0] >= MEM_BYTES) || (wctx_q.burst == BURST_WRAP);
    assign r_bad   = r_diff[64] || (r_diff[63:0] >= MEM_BYTES) || (rctx_q.burst == BURST_WRAP);
    assign w_hs    = w_ready_q && axi_req_i.w_valid;
    assign sram_we = w_hs && !w_bad && (wcnt_q <= {1'b0, wctx_q.len});
    assign sram_re = (r_state_q == R_FETCH);
    assign unused_bits = ^{axi_req_i.aw.atop, axi_req_i.aw.user, axi_req_i.ar.user,
                           axi_req_i.w.user, ID_WIDTH, RESP_LATENCY};

    axi_mem_sram #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_sram (
        .clk_i   (clk_i),
        .re_i    (sram_re),
        .raddr_i (r_diff[LSB +: IDXW]),
        .rdata_o (sram_rdata),
        .we_i    (sram_we),
        .waddr_i (w_diff[LSB +: IDXW]),
        .wbe_i   (axi_req_i.w.strb),
        .wdata_i (axi_req_i.w.data)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            w_state_q  <= W_IDLE;
            wctx_q     <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
`ifdef AXI_MEM_RESP_LAT_EN
            lat_w_q    <= '0;
`endif
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    aw_ready_q <= 1'b1;
                    if (aw_ready_q && axi_req_i.aw_valid) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        wctx_q     <= axi_req_i.aw.ctx;
                        wcnt_q     <= '0;
                        werr_q     <= 1'b0;
                        w_state_q  <= W_DATA;
                    end
                end
                W_DATA: if (w_hs) begin
                    wctx_q.addr <= next_beat_addr(wctx_q.addr, wctx_q.size, wctx_q.burst);
                    if (!wcnt_q[8]) wcnt_q <= wcnt_q + 9'd1;
                    werr_q <= werr_q | w_bad;
                    if (axi_req_i.w.last) begin
                        w_ready_q <= 1'b0;
                        b_resp_q  <= (werr_q || w_bad || (wcnt_q != {1'b0, wctx_q.len}))
                                     ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_MEM_RESP_LAT_EN
                        lat_w_q <= '0;
                        if (RESP_LATENCY == 0) begin
                            b_valid_q <= 1'b1;
                            w_state_q <= W_RESP;
                        end else begin
                            w_state_q <= W_WAIT;
                        end
`else
                        b_valid_q <= 1'b1;
                        w_state_q <= W_RESP;
`endif
                    end
                end
`ifdef AXI_MEM_RESP_LAT_EN
                W_WAIT: begin
                    lat_w_q <= lat_w_q + 16'd1;
                    if (lat_w_q == 16'(RESP_LATENCY - 1)) begin
                        b_valid_q <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
`endif
                W_RESP: if (axi_req_i.b_ready) begin
                    b_valid_q  <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_state_q  <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state_q  <= R_IDLE;
            rctx_q     <= '0;
            rbeat_q    <= '0;
            rerr_q     <= 1'b0;
            r_last_q   <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
`ifdef AXI_MEM_RESP_LAT_EN
            lat_r_q    <= '0;
`endif
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_ready_q && axi_req_i.ar_valid) begin
                        ar_ready_q <= 1'b0;
                        rctx_q     <= axi_req_i.ar.ctx;
                        rbeat_q    <= '0;
`ifdef AXI_MEM_RESP_LAT_EN
                        lat_r_q    <= '0;
                        r_state_q  <= (RESP_LATENCY == 0) ? R_FETCH : R_WAIT;
`else
                        r_state_q  <= R_FETCH;
`endif
                    end
                end
`ifdef AXI_MEM_RESP_LAT_EN
                R_WAIT: begin
                    lat_r_q <= lat_r_q + 16'd1;
                    if (lat_r_q == 16'(RESP_LATENCY - 1)) r_state_q <= R_FETCH;
                end
`endif
                // SRAM captures the word on this edge; beat status is captured alongside it.
                R_FETCH: begin
                    r_valid_q <= 1'b1;
                    rerr_q    <= r_bad;
                    r_resp_q  <= r_bad ? RESP_SLVERR : RESP_OKAY;
                    r_last_q  <= (rbeat_q == rctx_q.len);
                    r_state_q <= R_SEND;
                end
                R_SEND: if (axi_req_i.r_ready) begin
                    r_valid_q <= 1'b0;
                    if (r_last_q) begin
                        ar_ready_q <= 1'b1;
                        r_state_q  <= R_IDLE;
                    end else begin
                        rctx_q.addr <= next_beat_addr(rctx_q.addr, rctx_q.size, rctx_q.burst);
                        rbeat_q     <= rbeat_q + 8'd1;
                        r_state_q   <= R_FETCH;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready_q;
        axi_resp_o.w_ready  = w_ready_q;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.id     = wctx_q.id;
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r.id     = rctx_q.id;
        axi_resp_o.r.data   = rerr_q ? '0 : sram_rdata;
        axi_resp_o.r.resp   = r_resp_q;
        axi_resp_o.r.last   = r_last_q;
    end
endmodule
